// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA timing definitions.
//   CNT_W           : width of the h/v counters and fetch addresses
//   CNT_MAX         : largest axis total the counters can represent
//   vga_timing_t    : one complete timing set (both axes plus sync polarities)
//   VGA_640x480_60  : 800x525 total, negative syncs
//   VGA_800x600_40  : 1056x628 total, positive syncs
//   timing_total()  : active + porches + sync for one axis
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = 1 << CNT_W;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol: 1'b0,  vs_pol: 1'b0
    };

    localparam vga_timing_t VGA_800x600_40 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1,  vs_pol: 1'b1
    };

    function automatic int timing_total(input int active, input int fp,
                                         input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one raster axis: counts 0..TOTAL-1 and wraps.
// Ordering along the axis: active, front porch, sync, back porch.
//   clk, reset : clock, asynchronous active-high reset
//   ce         : advance enable
//   count      : current position
//   carry      : ce on the last position (enables the next axis)
//   active     : position inside [0, ACTIVE)
//   in_sync    : position inside [ACTIVE+FP, ACTIVE+FP+SYNC)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    output logic [CNT_W-1:0] count,
    output logic             carry,
    output logic             active,
    output logic             in_sync
);

    localparam int TOTAL = timing_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST_POS   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (ce) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    assign last    = (count == LAST_POS);
    assign carry   = ce && last;
    assign active  = (count < ACTIVE_END);
    assign in_sync = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout -- VGA raster generator with a latency-matched colour fetch.
// Optional feature: define VGA_TEST_PATTERN_EN to add test_mode (8 vertical
// colour bars replacing pixstream at the same latency).
//   clk_25_175     : pixel-domain clock
//   reset          : asynchronous active-high reset
//   hreadwire      : fetch column (live h counter)
//   vreadwire      : fetch row (live v counter)
//   pixstream      : fetched colour {b, g, r}, valid LAT-1 ticks after address
//   test_mode      : (VGA_TEST_PATTERN_EN only) select colour bars
//   h_sync, v_sync : syncs, delayed LAT ticks from the counters
//   r, g, b        : colour, forced to zero outside active video
//   drawing_pixels : active-video flag aligned with r/g/b and syncs
//   line_start     : one-clk strobe on the tick where h == 0
//   frame_start    : one-clk strobe on the tick where h == 0 and v == 0
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640x480_60.h_active,
    parameter int H_FP     = VGA_640x480_60.h_fp,
    parameter int H_SYNC   = VGA_640x480_60.h_sync,
    parameter int H_BP     = VGA_640x480_60.h_bp,
    parameter int V_ACTIVE = VGA_640x480_60.v_active,
    parameter int V_FP     = VGA_640x480_60.v_fp,
    parameter int V_SYNC   = VGA_640x480_60.v_sync,
    parameter int V_BP     = VGA_640x480_60.v_bp,
    parameter bit HS_POL   = VGA_640x480_60.hs_pol,
    parameter bit VS_POL   = VGA_640x480_60.vs_pol,
    parameter int COLOR_W  = 4,
    parameter int PIX_DIV  = 1,
    parameter int LAT      = 1
) (
    input  logic                 clk_25_175,
    input  logic                 reset,
    output logic [CNT_W-1:0]     hreadwire,
    output logic [CNT_W-1:0]     vreadwire,
    input  logic [3*COLOR_W-1:0] pixstream,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 h_sync,
    output logic                 v_sync,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 drawing_pixels,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
        $fatal(1, "vga_scanout: axis total exceeds counter range");
    end
    if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_bad_div
        $fatal(1, "vga_scanout: PIX_DIV out of range 1..8");
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $fatal(1, "vga_scanout: LAT out of range 1..4");
    end

    typedef struct packed {
        logic       vld;
        logic       hs;
        logic       vs;
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } ctl_t;

    logic [DIV_W-1:0]     div;
    logic                 pix_ce;
    logic [CNT_W-1:0]     h;
    logic [CNT_W-1:0]     v;
    logic                 h_carry;
    logic                 v_carry_unused;
    logic                 h_active;
    logic                 v_active;
    logic                 h_in_sync;
    logic                 v_in_sync;
    ctl_t                 ctl_p0;
    ctl_t                 ctl_s;
    logic [3*COLOR_W-1:0] colour_s;
    logic                 vld_p1;
    logic                 hs_p1;
    logic                 vs_p1;
    logic [3*COLOR_W-1:0] rgb_p1;

    // Pixel-tick divider: pix_ce is registered so it is low during reset and
    // first rises on the PIX_DIV-th edge after release.
    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else begin
            pix_ce <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h (
        .clk (clk_25_175), .reset (reset), .ce (pix_ce),
        .count (h), .carry (h_carry), .active (h_active), .in_sync (h_in_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v (
        .clk (clk_25_175), .reset (reset), .ce (h_carry),
        .count (v), .carry (v_carry_unused), .active (v_active), .in_sync (v_in_sync)
    );

    // Stage p0: address side, straight from the counters.
    assign hreadwire   = h;
    assign vreadwire   = v;
    assign line_start  = pix_ce && (h == '0);
    assign frame_start = line_start && (v == '0);

    always_comb begin
        ctl_p0     = '0;
        ctl_p0.vld = h_active && v_active;
        ctl_p0.hs  = h_in_sync;
        ctl_p0.vs  = v_in_sync;
`ifdef VGA_TEST_PATTERN_EN
        ctl_p0.bar = 3'((32'(h) * 8) / H_ACTIVE);
`endif
    end

    // Delay line: LAT-1 ticks, matching the pixel source latency so ctl_s
    // describes the address whose colour is on pixstream right now.
    if (LAT == 1) begin : g_no_dly
        assign ctl_s = ctl_p0;
    end else begin : g_dly
        ctl_t ctl_pd [LAT-1];

        always_ff @(posedge clk_25_175 or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LAT-1; i++) ctl_pd[i] <= '0;
            end else if (pix_ce) begin
                ctl_pd[0] <= ctl_p0;
                for (int i = 1; i < LAT-1; i++) ctl_pd[i] <= ctl_pd[i-1];
            end
        end

        assign ctl_s = ctl_pd[LAT-2];
    end

`ifdef VGA_TEST_PATTERN_EN
    assign colour_s = test_mode ? {{COLOR_W{ctl_s.bar[2]}},
                                   {COLOR_W{ctl_s.bar[1]}},
                                   {COLOR_W{ctl_s.bar[0]}}}
                                : pixstream;
`else
    assign colour_s = pixstream;
`endif

    // Stage p1: output register, LAT ticks behind the counters.
    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            rgb_p1 <= '0;
        end else if (pix_ce) begin
            vld_p1 <= ctl_s.vld;
            hs_p1  <= ctl_s.hs;
            vs_p1  <= ctl_s.vs;
            rgb_p1 <= ctl_s.vld ? colour_s : '0;
        end
    end

    assign drawing_pixels = vld_p1;
    assign h_sync         = hs_p1 ? HS_POL : ~HS_POL;
    assign v_sync         = vs_p1 ? VS_POL : ~VS_POL;
    assign r              = rgb_p1[COLOR_W-1:0];
    assign g              = rgb_p1[2*COLOR_W-1:COLOR_W];
    assign b              = rgb_p1[3*COLOR_W-1:2*COLOR_W];

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout -- randomized bench for vga_scanout on a reduced raster
// (24x10 total, PIX_DIV=2, LAT=3, mixed sync polarity). The reference model
// derives every expected output from the clock count since reset release.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int HA = 16, HF = 2, HW = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VW = 2, VB = 1;
    localparam int HT = HA + HF + HW + HB;
    localparam int VT = VA + VF + VW + VB;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int CW = 4, PD = 2, LT = 3;
    localparam int NT = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  hreadwire, vreadwire;
    logic [3*CW-1:0]   pixstream = '0;
    logic              h_sync, v_sync, drawing_pixels, line_start, frame_start;
    logic [CW-1:0]     r, g, b;
`ifdef VGA_TEST_PATTERN_EN
    logic              test_mode = 1'b0;
`endif
    bit                tmode = 1'b0;
    logic [3*CW-1:0]   data_mem [NT];
    int                checks = 0;
    int                failures = 0;

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VW), .V_BP (VB),
        .HS_POL (HP), .VS_POL (VP), .COLOR_W (CW), .PIX_DIV (PD), .LAT (LT)
    ) dut (
        .clk_25_175     (clk),
        .reset          (rst),
        .hreadwire      (hreadwire),
        .vreadwire      (vreadwire),
        .pixstream      (pixstream),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode      (test_mode),
`endif
        .h_sync         (h_sync),
        .v_sync         (v_sync),
        .r              (r),
        .g              (g),
        .b              (b),
        .drawing_pixels (drawing_pixels),
        .line_start     (line_start),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Pixel tick whose address is on the counters during cycle c
    // (cycle c = the interval after the c-th clock edge since release).
    function automatic int addr_tick(input int c);
        return (c == 0) ? 0 : (c - 1) / PD;
    endfunction

    task automatic check_reset_state(input string where);
        check({where, "_hread"},  32'(hreadwire), 0);
        check({where, "_vread"},  32'(vreadwire), 0);
        check({where, "_hsync"},  32'(h_sync), 32'(!HP));
        check({where, "_vsync"},  32'(v_sync), 32'(!VP));
        check({where, "_r"},      32'(r), 0);
        check({where, "_g"},      32'(g), 0);
        check({where, "_b"},      32'(b), 0);
        check({where, "_draw"},   32'(drawing_pixels), 0);
        check({where, "_lstart"}, 32'(line_start), 0);
        check({where, "_fstart"}, 32'(frame_start), 0);
    endtask

    task automatic check_cycle(input int c);
        int a, o, oh, ov, bar;
        bit ce, de, hs, vs;
        logic [3*CW-1:0] col;
        a  = addr_tick(c);
        ce = (c > 0) && (c % PD == 0);
        check("hreadwire",   32'(hreadwire),   a % HT);
        check("vreadwire",   32'(vreadwire),   (a / HT) % VT);
        check("line_start",  32'(line_start),  32'(ce && (a % HT == 0)));
        check("frame_start", 32'(frame_start), 32'(ce && (a % (HT * VT) == 0)));
        // outputs describe the address presented LT ticks earlier
        o   = a - LT;
        de  = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        col = '0;
        if (o >= 0) begin
            oh = o % HT;
            ov = (o / HT) % VT;
            de = (oh < HA) && (ov < VA);
            hs = (oh >= HA + HF) && (oh < HA + HF + HW);
            vs = (ov >= VA + VF) && (ov < VA + VF + VW);
            if (de) begin
                if (tmode) begin
                    bar = (oh * 8) / HA;
                    col = {((bar & 4) != 0) ? 4'hF : 4'h0,
                           ((bar & 2) != 0) ? 4'hF : 4'h0,
                           ((bar & 1) != 0) ? 4'hF : 4'h0};
                end else begin
                    col = data_mem[o];
                end
            end
        end
        check("drawing_pixels", 32'(drawing_pixels), 32'(de));
        check("h_sync", 32'(h_sync), 32'(hs ? HP : !HP));
        check("v_sync", 32'(v_sync), 32'(vs ? VP : !VP));
        check("r", 32'(r), 32'(col[CW-1:0]));
        check("g", 32'(g), 32'(col[2*CW-1:CW]));
        check("b", 32'(b), 32'(col[3*CW-1:2*CW]));
    endtask

    // Pixel source with LT-1 ticks of latency, timed from the bench's own count.
    task automatic drive_source(input int c);
        int idx;
        idx = addr_tick(c) - (LT - 1);
        pixstream = (idx >= 0 && idx < NT) ? data_mem[idx] : 12'($urandom);
    endtask

    task automatic run_segment(input int ncyc);
        for (int i = 0; i < NT; i++) data_mem[i] = 12'($urandom);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cycle(0);
        drive_source(0);
        for (int c = 1; c < ncyc; c++) begin
            @(negedge clk);
            check_cycle(c);
            drive_source(c);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");

        // One frame is HT*VT*PD = 480 clocks; stop somewhere in frame two.
        run_segment(700 + int'($urandom_range(0, 200)));

        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("async");
`ifdef VGA_TEST_PATTERN_EN
        tmode     = 1'b1;
        test_mode = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("hold");

        run_segment(2 * HT * VT * PD + 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
